// File: rtl/numlock_pkg.sv
// numlock_pkg: shared state indices, one-hot state encoding and defaults for numlock_fsm
package numlock_pkg;
    localparam int STATE_W          = 11;
    localparam int OPEN_CYCLES_DEF  = 16;
    localparam int ST_I             = 0;
    localparam int ST_G1GET         = 1;
    localparam int ST_G1            = 2;
    localparam int ST_G10GET        = 3;
    localparam int ST_G10           = 4;
    localparam int ST_G101GET       = 5;
    localparam int ST_G101          = 6;
    localparam int ST_G1011GET      = 7;
    localparam int ST_G1011         = 8;
    localparam int ST_OPENING       = 9;
    localparam int ST_BAD           = 10;
    typedef enum logic [STATE_W-1:0] {
        S_I         = STATE_W'(1 << ST_I),
        S_G1GET     = STATE_W'(1 << ST_G1GET),
        S_G1        = STATE_W'(1 << ST_G1),
        S_G10GET    = STATE_W'(1 << ST_G10GET),
        S_G10       = STATE_W'(1 << ST_G10),
        S_G101GET   = STATE_W'(1 << ST_G101GET),
        S_G101      = STATE_W'(1 << ST_G101),
        S_G1011GET  = STATE_W'(1 << ST_G1011GET),
        S_G1011     = STATE_W'(1 << ST_G1011),
        S_OPENING   = STATE_W'(1 << ST_OPENING),
        S_BAD       = STATE_W'(1 << ST_BAD)
    } state_e;
endpackage

// File: rtl/numlock_fsm.sv
// numlock_fsm: one-hot combination-lock controller for the button code 1-0-1-1
//   clk            rising-edge clock
//   reset          asynchronous active-low reset (returns to Initial)
//   U, Z           debounced "1" / "0" buttons, high = pressed
//   q_*            one-hot state flags decoded straight from the state register
//   Unlock         high for OPEN_CYCLES cycles after a correct code (same as q_Opening)
module numlock_fsm
    import numlock_pkg::*;
#(
    parameter int OPEN_CYCLES = OPEN_CYCLES_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic U,
    input  logic Z,
    output logic q_I,
    output logic q_G1get,
    output logic q_G1,
    output logic q_G10get,
    output logic q_G10,
    output logic q_G101get,
    output logic q_G101,
    output logic q_G1011get,
    output logic q_G1011,
    output logic q_Opening,
    output logic q_Bad,
    output logic Unlock
);
    state_e      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic        idle, one, zero, last;
    assign idle = ~U & ~Z;
    assign one  = U & ~Z;
    assign zero = Z & ~U;
    assign last = cnt_q == 16'(OPEN_CYCLES - 1);
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_I;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end
    // Each *GET state waits for full release so a held button counts once;
    // any non-one-hot pattern falls through to default and recovers to Initial.
    always_comb begin
        state_d = S_I;
        cnt_d   = '0;
        case (state_q)
            S_I:        state_d = one  ? S_G1GET     : Z ? S_BAD : S_I;
            S_G1GET:    state_d = idle ? S_G1        : S_G1GET;
            S_G1:       state_d = zero ? S_G10GET    : U ? S_BAD : S_G1;
            S_G10GET:   state_d = idle ? S_G10       : S_G10GET;
            S_G10:      state_d = one  ? S_G101GET   : Z ? S_BAD : S_G10;
            S_G101GET:  state_d = idle ? S_G101      : S_G101GET;
            S_G101:     state_d = one  ? S_G1011GET  : Z ? S_BAD : S_G101;
            S_G1011GET: state_d = idle ? S_G1011     : S_G1011GET;
            S_G1011:    state_d = S_OPENING;
            S_OPENING: begin
                state_d = last ? S_I : S_OPENING;
                cnt_d   = last ? '0 : cnt_q + 16'd1;
            end
            S_BAD:      state_d = idle ? S_I : S_BAD;
            default:    state_d = S_I;
        endcase
    end
    assign q_I        = state_q[ST_I];
    assign q_G1get    = state_q[ST_G1GET];
    assign q_G1       = state_q[ST_G1];
    assign q_G10get   = state_q[ST_G10GET];
    assign q_G10      = state_q[ST_G10];
    assign q_G101get  = state_q[ST_G101GET];
    assign q_G101     = state_q[ST_G101];
    assign q_G1011get = state_q[ST_G1011GET];
    assign q_G1011    = state_q[ST_G1011];
    assign q_Opening  = state_q[ST_OPENING];
    assign q_Bad      = state_q[ST_BAD];
    assign Unlock     = q_Opening;
endmodule

// File: tb/tb_numlock_fsm.sv
// tb_numlock_fsm: directed and randomized check of numlock_fsm against a digit-progress model
module tb_numlock_fsm;
    localparam int OPEN = 16;
    logic clk, reset, U, Z;
    logic q_I, q_G1get, q_G1, q_G10get, q_G10, q_G101get, q_G101;
    logic q_G1011get, q_G1011, q_Opening, q_Bad, Unlock;
    int tests, fails;
    int n, open_left, unlock_cnt;
    bit held, bad, armed;
    int code [4] = '{1, 0, 1, 1};
    numlock_fsm #(.OPEN_CYCLES(OPEN)) dut (
        .clk(clk), .reset(reset), .U(U), .Z(Z),
        .q_I(q_I), .q_G1get(q_G1get), .q_G1(q_G1), .q_G10get(q_G10get),
        .q_G10(q_G10), .q_G101get(q_G101get), .q_G101(q_G101),
        .q_G1011get(q_G1011get), .q_G1011(q_G1011), .q_Opening(q_Opening),
        .q_Bad(q_Bad), .Unlock(Unlock)
    );
    initial clk = 0;
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask
    task automatic model_reset();
        n = 0; held = 0; bad = 0; armed = 0; open_left = 0;
    endtask
    // Advance the progress model by one clock edge with the given buttons.
    task automatic model_step(input bit u, input bit z);
        if (open_left > 0) begin
            open_left--;
        end else if (armed) begin
            armed = 0; n = 0; open_left = OPEN;
        end else if (bad) begin
            if (!u && !z) begin bad = 0; n = 0; end
        end else if (held) begin
            if (!u && !z) begin held = 0; if (n == 4) armed = 1; end
        end else if (u && z) begin
            bad = 1;
        end else if (u || z) begin
            if (int'(u) == code[n]) begin n++; held = 1; end
            else bad = 1;
        end
    endtask
    function automatic int exp_state();
        if (open_left > 0) return 9;
        if (bad) return 10;
        if (armed) return 8;
        if (held) return 2 * n - 1;
        return 2 * n;
    endfunction
    task automatic check_all(input string tag);
        logic [10:0] flags;
        flags = {q_Bad, q_Opening, q_G1011, q_G1011get, q_G101, q_G101get,
                 q_G10, q_G10get, q_G1, q_G1get, q_I};
        chk({tag, "_flags"}, 32'(flags), 32'(1 << exp_state()));
        chk({tag, "_unlock"}, 32'(Unlock), 32'(exp_state() == 9));
    endtask
    task automatic step(input bit u, input bit z, input string tag);
        U = u; Z = z;
        @(posedge clk);
        if (!reset) model_reset(); else model_step(u, z);
        #1;
        unlock_cnt += int'(Unlock);
        check_all(tag);
    endtask
    task automatic press(input int d, input int hold, input int gap, input string tag);
        repeat (hold) step(d == 1, d == 0, tag);
        repeat (gap) step(0, 0, tag);
    endtask
    task automatic full_code(input string tag);
        press(1, 2, 2, tag); press(0, 2, 2, tag); press(1, 2, 2, tag); press(1, 2, 2, tag);
    endtask
    initial begin
        tests = 0; fails = 0; unlock_cnt = 0;
        U = 0; Z = 0; reset = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 check_all("reset");
        reset = 1;
        unlock_cnt = 0;
        full_code("code");
        repeat (20) step(0, 0, "open");
        chk("unlock_len", 32'(unlock_cnt), 32'(OPEN));
        press(0, 3, 2, "bad_first");
        unlock_cnt = 0;
        press(1, 2, 2, "bad3"); press(0, 2, 2, "bad3"); press(0, 2, 2, "bad3");
        chk("bad3_no_unlock", 32'(unlock_cnt), 0);
        press(1, 2, 2, "both"); step(1, 1, "both"); step(1, 1, "both"); step(0, 0, "both");
        unlock_cnt = 0;
        press(1, 10, 2, "long"); press(0, 2, 2, "long"); press(1, 2, 2, "long"); press(1, 2, 0, "long");
        repeat (20) step(0, 0, "long_open");
        chk("long_unlock_len", 32'(unlock_cnt), 32'(OPEN));
        press(1, 2, 2, "mid"); press(0, 2, 2, "mid"); press(1, 2, 2, "mid"); press(1, 2, 0, "mid");
        step(0, 0, "mid");
        repeat (5) step(0, 0, "mid_open");
        chk("mid_in_opening", 32'(Unlock), 1);
        reset = 0;
        #1;
        model_reset();
        check_all("async_reset");
        step(0, 0, "async_hold");
        reset = 1;
        unlock_cnt = 0;
        full_code("fresh");
        repeat (20) step(0, 0, "fresh_open");
        chk("fresh_unlock_len", 32'(unlock_cnt), 32'(OPEN));
        repeat (400) begin
            int kind, d;
            kind = int'($urandom_range(0, 15));
            d = (n < 4 && $urandom_range(0, 9) < 8) ? code[n] : int'($urandom_range(0, 1));
            if (kind == 0) begin
                step(1, 1, "rnd_both");
            end else if (kind == 1) begin
                step(0, 0, "rnd_idle");
            end else begin
                press(d, int'($urandom_range(1, 4)), int'($urandom_range(0, 3)), "rnd");
            end
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/numlock_fsm.md
Name: numlock_fsm

Overview:
- Synchronous 11-state combination-lock controller.
- Decodes a serial push-button code of 1-0-1-1 from two debounced buttons, U ("1") and Z ("0").
- On the correct code it asserts Unlock for a fixed opening window, then returns to idle.
- Sits behind the button debouncers. Exposes one-hot state flags for LED/diagnostic display.

Parameters:
- OPEN_CYCLES, 16, number of clock cycles spent in Opening with Unlock high (range 1..65535).

Ports:
- clk  in  1  system clock, rising-edge active.
- reset  in  1  asynchronous, active-low reset.
- U  in  1  "1" button, synchronous and debounced, high = pressed.
- Z  in  1  "0" button, synchronous and debounced, high = pressed.
- q_I  out  1  state flag: Initial.
- q_G1get  out  1  state flag: G1get.
- q_G1  out  1  state flag: G1.
- q_G10get  out  1  state flag: G10get.
- q_G10  out  1  state flag: G10.
- q_G101get  out  1  state flag: G101get.
- q_G101  out  1  state flag: G101.
- q_G1011get  out  1  state flag: G1011get.
- q_G1011  out  1  state flag: G1011.
- q_Opening  out  1  state flag: Opening.
- q_Bad  out  1  state flag: Bad.
- Unlock  out  1  lock-open command, equal to q_Opening.

Behaviour:
- One clock; reset is asynchronous and active-low.
- State register is one-hot, 11 bits. Exactly one q_* flag is high at all times.
- Flags and Unlock are decoded directly from registered state, with no extra latency.
- Reset (reset=0), taking effect immediately regardless of clk:
  - state = I, so q_I=1 and all other flags 0; Unlock=0.
  - Opening timer cleared to 0.
  - Reset mid-sequence or mid-Opening aborts to I.
- Transitions, evaluated at each rising clk edge. "Press" means exactly one button high; "both" means U=1 and Z=1.
  - I: U=1,Z=0 -> G1get. Z=1 (alone or both) -> Bad. Else stay.
  - G1get: U=0 and Z=0 -> G1. Else stay (button held).
  - G1: Z=1,U=0 -> G10get. U=1 (alone or both) -> Bad. Else stay.
  - G10get: U=0 and Z=0 -> G10. Else stay.
  - G10: U=1,Z=0 -> G101get. Z=1 (alone or both) -> Bad. Else stay.
  - G101get: U=0 and Z=0 -> G101. Else stay.
  - G101: U=1,Z=0 -> G1011get. Z=1 (alone or both) -> Bad. Else stay.
  - G1011get: U=0 and Z=0 -> G1011. Else stay.
  - G1011: unconditionally -> Opening next cycle. Timer loaded with 0.
  - Opening: Unlock=1. Timer increments each cycle. When timer = OPEN_CYCLES-1, go to I on that edge, so Opening lasts exactly OPEN_CYCLES cycles. Inputs are ignored.
  - Bad: U=0 and Z=0 -> I. Else stay.
- Each "get" state guarantees one physical press counts as one digit, however long it is held.
- A wrong digit at any entry step goes to Bad. Bad requires full release before a new attempt.
- Opening timer: 16-bit unsigned counter, active only in Opening, held at 0 elsewhere. No wrap is possible because the exit compare precedes overflow.
- An illegal or non-one-hot state (e.g. SEU) recovers to I on the next edge.

Decomposition:
- Shared package numlock_pkg:
  - state index constants (I=0, G1get=1, G1=2, G10get=3, G10=4, G101get=5, G101=6, G1011get=7, G1011=8, Opening=9, Bad=10);
  - state-vector width localparam (11);
  - default OPEN_CYCLES.
- Single module; no sub-module required. The opening counter is inline.

Test Plan:
- Reset: hold reset=0 for 2 cycles with U=Z=0 -> q_I=1, other flags 0, Unlock=0. Assert reset between edges -> outputs change without a clock.
- Correct code: press/release U, Z, U, U, each press 2 cycles with 2 idle cycles between.
  - Expected path: G1get, G1, G10get, G10, G101get, G101, G1011get, G1011, Opening.
  - Unlock=1 for exactly 16 cycles, then q_I=1.
- Wrong first digit: from I, press Z -> q_Bad next edge. Stay in Bad while Z held. Release -> q_I.
- Wrong third digit: enter 1,0 then press Z in G10 -> Bad. Unlock never asserts.
- Simultaneous U=Z=1 in G1 -> Bad. Long U hold (10 cycles) in G1get -> stays G1get, counted as one digit.
- Reset mid-Opening at cycle 5 of 16 -> immediately q_I=1, Unlock=0. A subsequent full code gives a fresh full-length window.
